// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF CRP sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

    localparam int          CW_DEF        = 32;
    localparam int          RW_DEF        = 4;
    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEF = 32'hACE1_2468;

    // Prefixed so the SETTLE state cannot collide with the SETTLE parameter.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_OUTPUT
    } state_t;

endpackage

// File: rtl/puf_lfsr.sv
// Galois right-shift LFSR producing the PUF challenge; zero seeds become 1.
// Latency: load/step take effect at the next clock edge; state is a register.
// Backpressure: none; the owner advances it only via step.
// Ports: clk, rst (sync, active-low), load/load_val (seed), step (advance), state (current value).
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int            CW   = CW_DEF,
    parameter logic [CW-1:0] SEED = CW'(LFSR_SEED_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          step,
    output logic [CW-1:0] state
);

    localparam logic [CW-1:0] POLY = CW'(LFSR_POLY);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SEED;
        end else if (load) begin
            // An all-zero state would lock the LFSR up forever.
            state <= (load_val == '0) ? CW'(1) : load_val;
        end else if (step) begin
            state <= state[0] ? ((state >> 1) ^ POLY) : (state >> 1);
        end
    end

endmodule

// File: rtl/puf_crp_sequencer.sv
// Collects majority-voted challenge/response pairs from the arbiter/MKG PUF array.
// Latency: out_valid rises NEVAL*(SETTLE+2) edges after the accepting start edge.
// Backpressure: OUTPUT holds out_chal/out_resp/chal stable until out_ready; no new evaluation starts.
// Ports: clk, rst (sync active-low); start/num_crp/seed_load/seed control; chal/puf_clr/puf_resp
// drive and sample the PUF; out_valid/out_ready/out_chal/out_resp CRP stream; busy/done status.
module puf_crp_sequencer
    import puf_pkg::*;
#(
    parameter int            CW        = CW_DEF,
    parameter int            RW        = RW_DEF,
    parameter int            NEVAL     = 5,
    parameter int            SETTLE    = 4,
    parameter logic [CW-1:0] LFSR_SEED = CW'(LFSR_SEED_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   num_crp,
    input  logic          seed_load,
    input  logic [CW-1:0] seed,
    output logic [CW-1:0] chal,
    output logic          puf_clr,
    input  logic [RW-1:0] puf_resp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_chal,
    output logic [RW-1:0] out_resp,
    output logic          busy,
    output logic          done
);

    localparam int OW = $clog2(NEVAL + 1);
    localparam int SW = $clog2(SETTLE + 1);

    state_t          state;
    logic [15:0]     num_crp_q;
    logic [15:0]     crp_cnt;
    logic [OW-1:0]   eval_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [OW-1:0]   ones [RW];
    logic [RW-1:0]   vote;
    logic            handshake;
    logic            last_crp;
    logic            lfsr_load;
    logic            lfsr_step;

    assign handshake = (state == ST_OUTPUT) && out_valid && out_ready;
    assign last_crp  = (crp_cnt == num_crp_q - 16'd1);
    // Seed load wins over a same-cycle start simply because the run's first
    // challenge is read from the LFSR only after this edge.
    assign lfsr_load = seed_load && (state == ST_IDLE);
    // The last handshake leaves the LFSR alone so the next run continues from it.
    assign lfsr_step = handshake && !last_crp;

    puf_lfsr #(
        .CW   (CW),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (seed),
        .step     (lfsr_step),
        .state    (chal)
    );

    // Vote includes the response being sampled this cycle, which is not yet in ones[].
    always_comb begin
        vote = '0;
        for (int i = 0; i < RW; i++) begin
            vote[i] = (ones[i] + OW'(puf_resp[i])) > OW'(NEVAL / 2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            num_crp_q  <= '0;
            crp_cnt    <= '0;
            eval_cnt   <= '0;
            settle_cnt <= '0;
            for (int i = 0; i < RW; i++) ones[i] <= '0;
            out_valid  <= 1'b0;
            out_resp   <= '0;
            out_chal   <= '0;
            puf_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_crp != 16'd0) begin
                            num_crp_q <= num_crp;
                            crp_cnt   <= '0;
                            eval_cnt  <= '0;
                            puf_clr   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_CLEAR;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    puf_clr    <= 1'b0;
                    settle_cnt <= '0;
                    if (eval_cnt == '0) begin
                        for (int i = 0; i < RW; i++) ones[i] <= '0;
                    end
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    for (int i = 0; i < RW; i++) ones[i] <= ones[i] + OW'(puf_resp[i]);
                    if (eval_cnt == OW'(NEVAL - 1)) begin
                        out_resp  <= vote;
                        out_chal  <= chal;
                        eval_cnt  <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else begin
                        eval_cnt <= eval_cnt + 1'b1;
                        puf_clr  <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                ST_OUTPUT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        crp_cnt   <= crp_cnt + 16'd1;
                        if (last_crp) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            puf_clr <= 1'b1;
                            state   <= ST_CLEAR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
